fp32_to_fp16_pipe: RTL and testbench

//  Multi-lane, pipelined IEEE-754 fp32 -> fp16 converter with valid/ready flow control.
//  - Selectable rounding; full handling of overflow, subnormal, NaN and Inf; per-lane exception flags.
//  - Sits between the fp32 accumulator drain and the fp16 output buffer of the matmul datapath.
//  - Successor to the single-lane combinational converter.

---
 rtl/fp32_to_fp16_pipe_if.sv | 31 +++
 rtl/fp32_to_fp16_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fp32_to_fp16_pipe.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_to_fp16_pipe_if.sv
// -----------------------------------------------------------------------------
// fp32_to_fp16_pipe_if
//   Handshake bundle between the fp32 accumulator drain, the converter and the
//   fp16 output buffer.
//   in_valid  / in_ready  : upstream valid/ready, in_data lane i = [32*i+:32]
//   out_valid / out_ready : downstream valid/ready, out_data lane i = [16*i+:16]
//   out_flags             : lane i = {ovf, unf, inexact} at [3*i+:3]
//   modport master : the side that feeds fp32 words and consumes fp16 words
//   modport slave  : the converter
// -----------------------------------------------------------------------------
interface fp32_to_fp16_pipe_if #(
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [32*LANES-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*LANES-1:0]   out_data;
    logic [3*LANES-1:0]    out_flags;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp32_to_fp16_pipe.sv
// -----------------------------------------------------------------------------
// fp32_to_fp16_pipe
//   Multi-lane, two-stage pipelined IEEE-754 fp32 -> fp16 converter with
//   valid/ready flow control and per-lane {ovf, unf, inexact} flags.
//   Stage 1 classifies each lane and aligns the significand to the fp16
//   fraction grid (guard/sticky kept); stage 2 rounds, packs and flags.
// Ports
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   bus     : slave side of fp32_to_fp16_pipe_if (in_*, out_*)
// Parameters
//   LANES      : independent lanes sharing one handshake
//   ROUND_MODE : 0 = round-to-nearest-even, 1 = round-toward-zero
// -----------------------------------------------------------------------------
module fp32_to_fp16_pipe #(
    parameter int LANES      = 4,
    parameter int ROUND_MODE = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    fp32_to_fp16_pipe_if.slave   bus
);

    // Lane classes decided in stage 1
    localparam logic [1:0] C_ROUND = 2'd0;  // normal or fp16-subnormal, needs rounding
    localparam logic [1:0] C_PASS  = 2'd1;  // NaN / Inf, exp+frac already final
    localparam logic [1:0] C_FLUSH = 2'd2;  // result is signed zero, stk = value lost
    localparam logic [1:0] C_OVF   = 2'd3;  // magnitude beyond fp16 range

    typedef struct packed {
        logic [1:0] cls;
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
        logic       grd;
        logic       stk;
    } s1_t;

    // Align one fp32 word onto the fp16 fraction grid.
    // {1,m} is placed at [47:24] and shifted right so that the fp16 fraction
    // lands in [33:24]; 13 for normals, 126-e for fp16 subnormals, which makes
    // bit 23 the guard and [22:0] the sticky in both cases.
    function automatic s1_t classify(input logic [31:0] a);
        s1_t         r;
        logic [7:0]  e;
        logic [22:0] m;
        logic [47:0] ext;
        logic [4:0]  sh;
        e   = a[30:23];
        m   = a[22:0];
        r   = '0;
        r.sign = a[31];
        ext = {1'b1, m, 24'h0};
        sh  = 5'd13;
        if (e == 8'hFF) begin
            r.cls  = C_PASS;
            r.exp  = 5'h1F;
            r.frac = (m != 23'h0) ? {1'b1, m[21:13]} : 10'h0;
        end else if (e == 8'h00) begin
            r.cls = C_FLUSH;
            r.stk = |m;
        end else if (e < 8'd102) begin
            r.cls = C_FLUSH;
            r.stk = 1'b1;
        end else if (e > 8'd142) begin
            r.cls = C_OVF;
        end else begin
            r.cls = C_ROUND;
            if (e >= 8'd113) begin
                r.exp = 5'(e - 8'd112);
            end else begin
                sh = 5'(8'd126 - e);
            end
            ext    = ext >> sh;
            r.frac = 10'(ext[47:24]);
            r.grd  = ext[23];
            r.stk  = |ext[22:0];
        end
        return r;
    endfunction

    // Magnitude returned on overflow: Inf for RNE, largest finite for RTZ
    function automatic logic [14:0] sat_mag();
        return (ROUND_MODE == 0) ? 15'h7C00 : 15'h7BFF;
    endfunction

    // Round, pack and flag one lane; returns {ovf, unf, inexact, fp16}.
    // Rounding is done on the packed {exp,frac} so a fraction carry bumps the
    // exponent for free. Overflow is judged on the nearest-even result in both
    // modes, so RTZ flags ovf on values that round past 65504 and saturates.
    function automatic logic [18:0] round_pack(input s1_t p);
        logic        inc_rne;
        logic        inc;
        logic        lost;
        logic [14:0] mag;
        logic [14:0] sum_rne;
        logic [14:0] sum;
        logic [2:0]  fl;
        logic [15:0] res;
        mag     = {p.exp, p.frac};
        lost    = p.grd | p.stk;
        inc_rne = p.grd & (p.stk | p.frac[0]);
        inc     = (ROUND_MODE == 0) ? inc_rne : 1'b0;
        sum_rne = mag + {14'd0, inc_rne};
        sum     = mag + {14'd0, inc};
        res     = {p.sign, 15'h0};
        fl      = 3'b000;
        case (p.cls)
            C_PASS:  res = {p.sign, mag};
            C_FLUSH: fl  = {1'b0, p.stk, p.stk};
            C_OVF: begin
                res = {p.sign, sat_mag()};
                fl  = 3'b101;
            end
            default: begin
                if (sum_rne[14:10] == 5'h1F) begin
                    res = {p.sign, sat_mag()};
                    fl  = 3'b101;
                end else begin
                    res = {p.sign, sum};
                    fl  = {1'b0, (sum[14:10] == 5'h00) & lost, lost};
                end
            end
        endcase
        return {fl, res};
    endfunction

    logic                 w_adv1;
    logic                 w_adv2;
    s1_t                  w_cls   [LANES];
    logic [16*LANES-1:0]  w_data;
    logic [3*LANES-1:0]   w_flags;

    logic                 r_vld_p1;
    s1_t                  r_lane_p1 [LANES];
    logic                 r_vld_p2;
    logic [16*LANES-1:0]  r_data_p2;
    logic [3*LANES-1:0]   r_flags_p2;

    assign w_adv2       = !r_vld_p2 || bus.out_ready;
    assign w_adv1       = !r_vld_p1 || w_adv2;
    assign bus.in_ready = w_adv1;

    always_comb begin
        w_cls   = '{default: '0};
        w_data  = '0;
        w_flags = '0;
        for (int i = 0; i < LANES; i++) begin
            w_cls[i] = classify(bus.in_data[32*i +: 32]);
            {w_flags[3*i +: 3], w_data[16*i +: 16]} = round_pack(r_lane_p1[i]);
        end
    end

    // ---- stage 1: classify / align ----
    always_ff @(posedge clk) begin
        if (w_adv1) begin
            for (int i = 0; i < LANES; i++) begin
                r_lane_p1[i] <= w_cls[i];
            end
        end
    end

    // ---- stage 2: round / pack / flags, drives the output port ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_data_p2  <= '0;
            r_flags_p2 <= '0;
        end else begin
            if (w_adv1) begin
                r_vld_p1 <= bus.in_valid;
            end
            if (w_adv2) begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_data_p2  <= w_data;
                    r_flags_p2 <= w_flags;
                end
            end
        end
    end

    assign bus.out_valid = r_vld_p2;
    assign bus.out_data  = r_data_p2;
    assign bus.out_flags = r_flags_p2;

endmodule

// File: tb/tb_fp32_to_fp16_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp32_to_fp16_pipe
//   Drives an RNE and an RTZ instance of fp32_to_fp16_pipe with identical
//   stimulus. Expected results come from an independent integer model
//   (quotient/remainder rounding) pushed to queues on accept and popped when
//   the converter delivers; a few directed word-sets also carry hand-written
//   expected constants and latency checks.
// -----------------------------------------------------------------------------
module tb_fp32_to_fp16_pipe;

    localparam int LANES = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    fp32_to_fp16_pipe_if #(.LANES(LANES)) bus_n ();
    fp32_to_fp16_pipe_if #(.LANES(LANES)) bus_z ();

    logic       rdy_const = 1'b1;
    logic       rdy_pat   = 1'b0;
    logic [1:0] pat_idx   = 2'd0;
    logic       pat_bit;

    // out_ready pattern 1,0,0,1 when enabled
    assign pat_bit         = (pat_idx == 2'd0) || (pat_idx == 2'd3);
    assign bus_n.out_ready = rdy_pat ? pat_bit : rdy_const;
    assign bus_z.out_ready = bus_n.out_ready;
    assign bus_z.in_valid  = bus_n.in_valid;
    assign bus_z.in_data   = bus_n.in_data;

    always begin
        @(posedge clk);
        #1;
        pat_idx = pat_idx + 2'd1;
    end

    fp32_to_fp16_pipe #(.LANES(LANES), .ROUND_MODE(0)) dut_rne (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_n.slave)
    );

    fp32_to_fp16_pipe #(.LANES(LANES), .ROUND_MODE(1)) dut_rtz (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_z.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference: value = sig * 2^(e-150); quantise to the fp16 ulp with an
    // integer quotient and remainder, then rebuild the fp16 encoding.
    function automatic logic [18:0] ref_conv(input logic [31:0] a, input bit rtz);
        logic   s;
        int     e, ue, k;
        longint sig, q, qn, rem, half, mag_n, mag_z, mag;
        bit     inx, unf;
        s   = a[31];
        e   = int'(a[30:23]);
        sig = longint'({1'b1, a[22:0]});
        if (e == 255)
            return (a[22:0] != 0) ? {3'b000, s, 5'h1F, 1'b1, a[21:13]} : {3'b000, s, 15'h7C00};
        if (e == 0)
            return {1'b0, a[22:0] != 0, a[22:0] != 0, s, 15'h0};
        ue = e - 127;
        k  = (ue >= -14) ? 13 : 126 - e;
        if (k > 40) begin
            q = 0; qn = 0; inx = 1'b1;
        end else begin
            q    = sig >> k;
            rem  = sig & ((longint'(1) << k) - 1);
            half = longint'(1) << (k - 1);
            qn   = q + (((rem > half) || (rem == half && q[0])) ? longint'(1) : longint'(0));
            inx  = (rem != 0);
        end
        if (ue >= -14) begin
            mag_n = (longint'(ue + 15) << 10) + qn - 1024;
            mag_z = (longint'(ue + 15) << 10) + q - 1024;
        end else begin
            mag_n = qn;
            mag_z = q;
        end
        if (mag_n >= longint'(32'h7C00))
            return {3'b101, s, rtz ? 15'h7BFF : 15'h7C00};
        mag = rtz ? mag_z : mag_n;
        unf = (mag < 1024) && inx;
        return {1'b0, unf, inx, s, mag[14:0]};
    endfunction

    function automatic logic [75:0] ref_set(input logic [127:0] d, input bit rtz);
        logic [63:0] od;
        logic [11:0] of;
        logic [18:0] r;
        od = '0;
        of = '0;
        for (int i = 0; i < LANES; i++) begin
            r = ref_conv(d[32*i +: 32], rtz);
            od[16*i +: 16] = r[15:0];
            of[3*i +: 3]   = r[18:16];
        end
        return {of, od};
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[30:23] = 8'($urandom_range(98, 146));
            1: w[30:23] = 8'($urandom_range(110, 130));
            2: begin
                case ($urandom_range(0, 3))
                    0: w[30:23] = 8'd0;
                    1: w[30:23] = 8'd255;
                    2: w[30:23] = 8'd142;
                    default: w[30:23] = 8'd112;
                endcase
            end
            default: ;
        endcase
        return w;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [75:0] q_n [$];
    logic [75:0] q_z [$];
    logic [75:0] e_n, e_z;
    bit          mon_on     = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;
    int          occ;

    always @(negedge clk) begin
        if (resetn === 1'b1 && mon_on) begin
            occ = q_n.size();
            chk("in_ready", 64'(bus_n.in_ready), 64'(!(occ == 2 && !bus_n.out_ready)));
            chk("in_ready_rtz", 64'(bus_z.in_ready), 64'(!(occ == 2 && !bus_n.out_ready)));
            if (prev_stall && bus_n.out_valid)
                chk("stall_hold", bus_n.out_data, prev_data);
            prev_stall = bus_n.out_valid && !bus_n.out_ready;
            prev_data  = bus_n.out_data;
            if (bus_n.in_valid && bus_n.in_ready) begin
                q_n.push_back(ref_set(bus_n.in_data, 1'b0));
                q_z.push_back(ref_set(bus_n.in_data, 1'b1));
            end
            if (bus_n.out_valid && bus_n.out_ready) begin
                if (q_n.size() == 0) begin
                    chk("unexpected_out", 64'(bus_n.out_valid), 64'd0);
                end else begin
                    e_n = q_n.pop_front();
                    e_z = q_z.pop_front();
                    chk("sb_data_rne",  bus_n.out_data,       e_n[63:0]);
                    chk("sb_flags_rne", 64'(bus_n.out_flags), 64'(e_n[75:64]));
                    chk("sb_valid_rtz", 64'(bus_z.out_valid), 64'd1);
                    chk("sb_data_rtz",  bus_z.out_data,       e_z[63:0]);
                    chk("sb_flags_rtz", 64'(bus_z.out_flags), 64'(e_z[75:64]));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers (entered at posedge+1) ----------------
    task automatic send(input logic [127:0] d);
        bit ok;
        ok = 1'b0;
        bus_n.in_valid = 1'b1;
        bus_n.in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus_n.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus_n.in_valid = 1'b0;
    endtask

    task automatic latency_check(input string tag, input logic [127:0] d,
                                 input logic [63:0] en, input logic [11:0] fn,
                                 input logic [63:0] ez, input logic [11:0] fz);
        bus_n.in_valid = 1'b1;
        bus_n.in_data  = d;
        @(negedge clk);
        chk({tag, "_accept"}, 64'(bus_n.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus_n.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1_valid"}, 64'(bus_n.out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_lat2_valid"}, 64'(bus_n.out_valid), 64'd1);
        chk({tag, "_data_rne"},  bus_n.out_data,       en);
        chk({tag, "_flags_rne"}, 64'(bus_n.out_flags), 64'(fn));
        chk({tag, "_data_rtz"},  bus_z.out_data,       ez);
        chk({tag, "_flags_rtz"}, 64'(bus_z.out_flags), 64'(fz));
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] SET1 = {32'h3F803000, 32'h477FF000, 32'hC0490FDB, 32'h3F800000};
    localparam logic [127:0] SET2 = {32'h80000001, 32'h33000000, 32'h33800000, 32'h38800000};
    localparam logic [127:0] SET3 = {32'h3F801000, 32'h7F800001, 32'hFF800000, 32'h7FC00001};

    initial begin
        bus_n.in_valid = 1'b0;
        bus_n.in_data  = '0;
        resetn         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus_n.out_valid), 64'd0);
        chk("rst_data",  bus_n.out_data,       64'd0);
        chk("rst_flags", 64'(bus_n.out_flags), 64'd0);
        resetn = 1'b1;
        mon_on = 1'b1;
        @(posedge clk);
        #1;

        // directed sets with hand-written expectations and 2-cycle latency
        latency_check("set1", SET1,
                      64'h3C02_7C00_C248_3C00, 12'b001_101_001_000,
                      64'h3C01_7BFF_C248_3C00, 12'b001_101_001_000);
        latency_check("set2", SET2,
                      64'h8000_0000_0001_0400, 12'b011_011_000_000,
                      64'h8000_0000_0001_0400, 12'b011_011_000_000);
        latency_check("set3", SET3,
                      64'h3C00_7E00_FC00_7E00, 12'b001_000_000_000,
                      64'h3C00_7E00_FC00_7E00, 12'b001_000_000_000);

        // back-to-back full-throughput burst through the scoreboard
        send(SET2);
        send(SET3);
        send(SET1);
        repeat (4) @(posedge clk);
        #1;

        // stream with out_ready toggling 1,0,0,1 and random input gaps
        rdy_pat = 1'b1;
        for (int n = 0; n < 8; n++) begin
            logic [127:0] d;
            for (int l = 0; l < LANES; l++) d[32*l +: 32] = rnd_word();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(d);
        end
        for (int t = 0; t < 200 && q_n.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("stream_drained", 64'(q_n.size()), 64'd0);
        rdy_pat   = 1'b0;
        rdy_const = 1'b1;
        @(posedge clk);
        #1;

        // reset with both stages full and downstream stalled
        rdy_const = 1'b0;
        send(SET1);
        send(SET2);
        @(negedge clk);
        chk("full_valid", 64'(bus_n.out_valid), 64'd1);
        chk("full_in_ready", 64'(bus_n.in_ready), 64'd0);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_rst_valid",     64'(bus_n.out_valid), 64'd0);
        chk("async_rst_data",      bus_n.out_data,       64'd0);
        chk("async_rst_flags",     64'(bus_n.out_flags), 64'd0);
        chk("async_rst_valid_rtz", 64'(bus_z.out_valid), 64'd0);
        chk("async_rst_data_rtz",  bus_z.out_data,       64'd0);
        q_n.delete();
        q_z.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn    = 1'b1;
        rdy_const = 1'b1;
        @(negedge clk);
        chk("post_rst_no_stale", 64'(bus_n.out_valid), 64'd0);
        @(posedge clk);
        #1;
        latency_check("post_rst", SET3,
                      64'h3C00_7E00_FC00_7E00, 12'b001_000_000_000,
                      64'h3C00_7E00_FC00_7E00, 12'b001_000_000_000);
        repeat (2) @(posedge clk);
        #1;
        chk("final_drained", 64'(q_n.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
